imem_line_responder: RTL

//  Instruction-memory responder that sits on the far side of the fetch stage's
//  I-mem port. It serves imem_addr/imem_rmask requests with imem_rdata/imem_resp.

---
 rtl/imem_line_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/imem_line_responder.sv
// Instruction-memory responder: direct-mapped line store answering fetch lookups
// with one-cycle latency, refilled line-at-a-time from a burst backing memory.
module imem_line_responder #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned NUM_LINES  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic        inv,
    output logic [31:0] bmem_addr,
    output logic        bmem_read,
    input  logic        bmem_ready,
    input  logic [31:0] bmem_rdata,
    input  logic        bmem_rvalid
);

    localparam int unsigned OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;
    localparam int unsigned WORD_W = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic                resp_q, resp_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                bmem_read_q, bmem_read_d;
    logic [31:0]         bmem_addr_q, bmem_addr_d;
    logic                inv_pend_q, inv_pend_d;
    logic [WORD_W-1:0]   beat_q, beat_d;

    logic [31:0]         data_q [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]    tag_q  [NUM_LINES];
    logic                data_we, tag_we;

    logic [IDX_W-1:0]    req_idx, fill_idx;
    logic [TAG_W-1:0]    req_tag, fill_tag;
    logic [WORD_W-1:0]   req_word;
    logic                hit;
    logic                addr_lo_unused;

    always_comb begin
        req_idx        = imem_addr[OFF_W+IDX_W-1:OFF_W];
        req_tag        = imem_addr[31:OFF_W+IDX_W];
        req_word       = imem_addr[OFF_W-1:2];
        fill_idx       = bmem_addr_q[OFF_W+IDX_W-1:OFF_W];
        fill_tag       = bmem_addr_q[31:OFF_W+IDX_W];
        hit            = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        addr_lo_unused = ^imem_addr[1:0];
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        resp_d      = 1'b0;
        rdata_d     = rdata_q;
        bmem_read_d = bmem_read_q;
        bmem_addr_d = bmem_addr_q;
        inv_pend_d  = inv_pend_q;
        beat_d      = beat_q;
        data_we     = 1'b0;
        tag_we      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (inv) begin
                    valid_d = '0;
                end else if (imem_rmask != 4'b0000) begin
                    if (hit) begin
                        resp_d  = 1'b1;
                        rdata_d = data_q[req_idx][req_word];
                    end else begin
                        bmem_addr_d = {imem_addr[31:OFF_W], {OFF_W{1'b0}}};
                        bmem_read_d = 1'b1;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (inv) inv_pend_d = 1'b1;
                if (bmem_ready) begin
                    bmem_read_d = 1'b0;
                    beat_d      = '0;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (inv) inv_pend_d = 1'b1;
                if (bmem_rvalid) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == WORD_W'(LINE_WORDS - 1)) begin
                        state_d = S_IDLE;
                        // An invalidate seen at any point of the refill, including
                        // on the last beat itself, discards the line and clears all.
                        if (inv_pend_q || inv) begin
                            valid_d    = '0;
                            inv_pend_d = 1'b0;
                        end else begin
                            valid_d[fill_idx] = 1'b1;
                            tag_we            = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            resp_q      <= 1'b0;
            rdata_q     <= 32'h0000_0013;
            bmem_read_q <= 1'b0;
            bmem_addr_q <= '0;
            inv_pend_q  <= 1'b0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            resp_q      <= resp_d;
            rdata_q     <= rdata_d;
            bmem_read_q <= bmem_read_d;
            bmem_addr_q <= bmem_addr_d;
            inv_pend_q  <= inv_pend_d;
            beat_q      <= beat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we && !rst) data_q[fill_idx][beat_q] <= bmem_rdata;
        if (tag_we && !rst)  tag_q[fill_idx] <= fill_tag;
    end

    always_comb begin
        imem_resp  = resp_q;
        imem_rdata = rdata_q;
        bmem_read  = bmem_read_q;
        bmem_addr  = bmem_addr_q;
    end

endmodule
